// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared codes, sizes and BCD helper for the product display path
package display_pkg;
    localparam logic [3:0] DIG_MINUS  = 4'd10;
    localparam logic [3:0] DIG_BLANK  = 4'd11;
    localparam int         BCD_DIGITS = 5;
    localparam int         BCD_BITS   = 4 * BCD_DIGITS;
    localparam int         BCD_ITERS  = 16;

    // Pre-shift correction of the double-dabble step: nibbles >= 5 get +3.
    function automatic logic [BCD_BITS-1:0] bcd_add3(input logic [BCD_BITS-1:0] b);
        logic [BCD_BITS-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to BCD engine, one bit per cycle
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [15:0]         mag,
    output logic                busy,
    output logic                done,
    output logic                last,
    output logic [BCD_BITS-1:0] bcd
);
    logic [15:0]         mag_q, mag_d;
    logic [BCD_BITS-1:0] bcd_q, bcd_d;
    logic [3:0]          iter_q, iter_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BCD_BITS-1:0] bcd_sh;
    logic [15:0]         mag_sh;
    logic                last_c;

    always_comb begin
        {bcd_sh, mag_sh} = {bcd_add3(bcd_q), mag_q} << 1;
        last_c  = busy_q && (iter_q == 4'(BCD_ITERS - 1));
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        done_d  = last_c;
        if (busy_q) begin
            mag_d  = mag_sh;
            bcd_d  = bcd_sh;
            iter_d = iter_q + 4'd1;
            if (last_c) begin
                busy_d = 1'b0;
            end
        end else if (load) begin
            mag_d  = mag;
            bcd_d  = '0;
            iter_d = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mag_q  <= mag_d;
            bcd_q  <= bcd_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // bcd carries the final result while last is high, so the owner can commit on that edge.
    assign busy = busy_q;
    assign done = done_q;
    assign last = last_c;
    assign bcd  = bcd_sh;
endmodule

// File: rtl/product_display_driver.sv
// rtl/product_display_driver.sv - signed product to multiplexed sign + 3-digit 7-segment stream
module product_display_driver
    import display_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       win,
    output logic             busy,
    output logic             done,
    output logic [1:0]       en,
    output logic [3:0]       num
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [WIDTH-1:0]    mag_in;
    logic                conv_busy, conv_done, conv_last;
    logic [BCD_BITS-1:0] conv_bcd;

    logic                sgn_pend_q, sgn_pend_d;
    logic                sign_q, sign_d;
    logic [BCD_BITS-1:0] digits_q, digits_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          en_q, en_d;
    logic [3:0]          num_q, num_d;
    logic                wrap;
    int                  idx;
    int                  w;

    assign mag_in = value[WIDTH-1] ? (~value + 1'b1) : value;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .mag   (mag_in),
        .busy  (conv_busy),
        .done  (conv_done),
        .last  (conv_last),
        .bcd   (conv_bcd)
    );

    always_comb begin
        sgn_pend_d = (load && !conv_busy) ? value[WIDTH-1] : sgn_pend_q;
        sign_d     = conv_last ? sgn_pend_q : sign_q;
        digits_d   = conv_last ? conv_bcd : digits_q;
        wrap       = (cnt_q == CW'(REFRESH_DIV - 1));
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        en_d       = wrap ? en_q + 2'd1 : en_q;
        w          = (win == 2'd3) ? 2 : int'(win);
        idx        = w + 3 - int'(en_d);
        num_d      = num_q;
        // Mux from the next-state digits so a commit on a scan edge is shown at once.
        if (wrap) begin
            if (en_d == 2'd0) begin
                num_d = (sign_d && (digits_d != '0)) ? DIG_MINUS : DIG_BLANK;
            end else begin
                num_d = 4'(digits_d >> (4 * idx));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_pend_q <= 1'b0;
            sign_q     <= 1'b0;
            digits_q   <= '0;
            cnt_q      <= '0;
            en_q       <= 2'd0;
            num_q      <= DIG_BLANK;
        end else begin
            sgn_pend_q <= sgn_pend_d;
            sign_q     <= sign_d;
            digits_q   <= digits_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            num_q      <= num_d;
        end
    end

    assign busy = conv_busy;
    assign done = conv_done;
    assign en   = en_q;
    assign num  = num_q;
endmodule

// File: tb/tb_product_display_driver.sv
// tb/tb_product_display_driver.sv - scoreboard bench for product_display_driver
module tb_product_display_driver;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [1:0]  win = 2'd0;
    logic        busy, done;
    logic [1:0]  en;
    logic [3:0]  num;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [3:0]  sgn;
        logic [19:0] dig;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;

    product_display_driver #(.WIDTH(16), .REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .win   (win),
        .busy  (busy),
        .done  (done),
        .en    (en),
        .num   (num)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int v);
        exp_t r;
        int   m;
        int   p;
        m = (v < 0) ? -v : v;
        r.sgn = (v < 0 && m != 0) ? 4'd10 : 4'd11;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r.dig[4*i +: 4] = 4'((m / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_num(input exp_t e, input logic [1:0] pos, input logic [1:0] wn);
        int w;
        w = (wn == 2'd3) ? 2 : int'(wn);
        if (pos == 2'd0) return e.sgn;
        return e.dig[4*(w + 3 - int'(pos)) +: 4];
    endfunction

    task automatic do_load(input int v, input bit interfere, input int v2);
        bit got;
        sb_q.push_back(model(v));
        value = 16'(v);
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
        check("busy_after_load", busy, 1);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (interfere && k == 5) begin
                value = 16'(v2);
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            if (k < 16) check($sformatf("busy_edge%0d", k), busy, 1);
            if (k == 15) check("done_early", done, 0);
            if (k == 16) begin
                check("done_edge16", done, 1);
                check("busy_clear_edge16", busy, 0);
            end
        end
        load = 1'b0;
        got = done;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            got = done;
        end
        if (!got) check("done_timeout", 0, 1);
        if (sb_q.size() > 0) cur = sb_q.pop_front();
        else check("sb_underflow", 0, 1);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    task automatic scan_check(input string tag);
        logic [1:0] prev;
        int since;
        int trans;
        int cyc;
        prev  = en;
        since = 0;
        trans = 0;
        cyc   = 0;
        while (trans < 4 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            since++;
            if (en !== prev) begin
                if (trans > 0) check({tag, "_interval"}, since, DIV);
                check({tag, "_en_step"}, en, 2'(prev + 2'd1));
                check($sformatf("%s_num_en%0d", tag, en), num, exp_num(cur, en, win));
                prev  = en;
                since = 0;
                trans++;
            end
        end
        if (trans < 4) check({tag, "_scan_timeout"}, trans, 4);
    endtask

    initial begin
        #12;
        check("rst_en", en, 0);
        check("rst_num", num, 11);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        win = 2'd0;
        do_load(1234, 1'b0, 0);
        scan_check("c2_1234");

        // Abort a conversion with reset, away from any clock edge.
        sb_q.push_back(model(-16384));
        value = 16'(-16384);
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_en", en, 0);
        check("midrst_num", num, 11);
        check("midrst_busy", busy, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        cur = model(0);
        scan_check("c1_after_reset");
        check("after_reset_busy", busy, 0);

        win = 2'd2;
        do_load(-16384, 1'b0, 0);
        scan_check("c3_w2");
        win = 2'd0;
        scan_check("c3_w0");

        win = 2'd2;
        do_load(-32768, 1'b0, 0);
        scan_check("c4_min");
        do_load(0, 1'b0, 0);
        scan_check("c4_zero");

        win = 2'd0;
        do_load(99, 1'b1, 55);
        scan_check("c5_ignore");

        win = 2'd1;
        do_load(-1234, 1'b0, 0);
        scan_check("w1_neg");
        win = 2'd3;
        do_load(-5, 1'b0, 0);
        scan_check("w3_small");
        win = 2'd0;
        do_load(32767, 1'b0, 0);
        scan_check("max_pos");

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
